// File: rtl/pkg_cpu.sv
// pkg_cpu: shared CPU-side request encodings, memory controller state and bus types.
package pkg_cpu;

    localparam logic [1:0] ReqDataSz8  = 2'd0;
    localparam logic [1:0] ReqDataSz16 = 2'd1;
    localparam logic [1:0] ReqDataSz32 = 2'd2;
    localparam logic [1:0] ReqDataSz48 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        DONE
    } MemCtrlState;

    // Address lives outside the struct because its width is a module parameter.
    typedef struct packed {
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        rd;
        logic        wr;
    } StrcMemBusOut;

    function automatic logic [1:0] last_beat(input logic [1:0] sz);
        return sz == ReqDataSz48 ? 2'd2 : sz == ReqDataSz32 ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/plain_adder.sv
// PlainAdder: unsigned adder, result wraps modulo 2^WIDTH.
module PlainAdder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: splits CPU read/write requests into 16-bit memory beats,
// stalling the CPU until the transfer completes, errors or times out.
module cpu_mem_ctrl
    import pkg_cpu::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_rd,
    input  logic                  cpu_req_wr,
    input  logic [1:0]            cpu_req_sz,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wr_data,
    output logic                  cpu_enable,
    output logic [47:0]           cpu_data_in,
    output logic                  bus_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic [1:0]            mem_be,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ack
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    MemCtrlState           state, state_n;
    StrcMemBusOut          bus, bus_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n, addr_inc;
    logic [WW-1:0]         wait_cnt, wait_n;
    logic [1:0]            beat_cnt, beat_n, sz, sz_n;
    logic [47:0]           stage, stage_n, data_q, data_n;
    logic [15:0]           wdata_hi, wdata_hi_n, rbeat;
    logic                  lane, lane_n, err_q, err_n;
    logic                  req, illegal, ack, last;

    PlainAdder #(.WIDTH(ADDR_WIDTH)) u_next_addr (
        .a   (addr_q),
        .b   (ADDR_WIDTH'(2)),
        .sum (addr_inc)
    );

    assign req     = cpu_req_rd | cpu_req_wr;
    assign illegal = (cpu_req_rd & cpu_req_wr)
                   | (cpu_req_wr & (cpu_req_sz == ReqDataSz48))
                   | ((cpu_req_sz != ReqDataSz8) & cpu_addr[0]);
    assign ack     = (bus.rd | bus.wr) & mem_ack;
    assign last    = beat_cnt == last_beat(sz);
    assign rbeat   = sz == ReqDataSz8 ? {8'h00, lane ? mem_rdata[15:8] : mem_rdata[7:0]} : mem_rdata;

    assign cpu_enable  = (state == DONE) | ((state == IDLE) & ~req);
    assign cpu_data_in = data_q;
    assign bus_err     = err_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = bus.wdata;
    assign mem_be      = bus.be;
    assign mem_rd      = bus.rd;
    assign mem_wr      = bus.wr;

    always_comb begin
        state_n    = state;
        bus_n      = bus;
        addr_n     = addr_q;
        wait_n     = wait_cnt;
        beat_n     = beat_cnt;
        sz_n       = sz;
        lane_n     = lane;
        wdata_hi_n = wdata_hi;
        stage_n    = stage;
        data_n     = data_q;
        err_n      = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (illegal) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                end else begin
                    state_n     = BEAT;
                    addr_n      = {cpu_addr[ADDR_WIDTH-1:1], 1'b0};
                    sz_n        = cpu_req_sz;
                    lane_n      = cpu_addr[0];
                    wdata_hi_n  = cpu_wr_data[31:16];
                    beat_n      = 2'd0;
                    wait_n      = '0;
                    stage_n     = '0;
                    bus_n.rd    = cpu_req_rd;
                    bus_n.wr    = cpu_req_wr;
                    bus_n.be    = cpu_req_sz == ReqDataSz8 ? (cpu_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                    bus_n.wdata = cpu_req_sz == ReqDataSz8 ? {2{cpu_wr_data[7:0]}} : cpu_wr_data[15:0];
                end
            end
            BEAT: if (ack) begin
                stage_n[{beat_cnt, 4'b0} +: 16] = rbeat;
                wait_n = '0;
                if (last) begin
                    state_n  = DONE;
                    bus_n.rd = 1'b0;
                    bus_n.wr = 1'b0;
                    data_n   = bus.rd ? stage_n : data_q;
                end else begin
                    beat_n      = beat_cnt + 2'd1;
                    addr_n      = addr_inc;
                    bus_n.wdata = beat_cnt == 2'd0 ? wdata_hi : 16'h0000;
                end
            end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                // Abort: completed write beats stay written, read data is discarded.
                state_n  = DONE;
                bus_n.rd = 1'b0;
                bus_n.wr = 1'b0;
                err_n    = 1'b1;
                wait_n   = '0;
            end else begin
                wait_n = wait_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bus      <= '0;
            addr_q   <= '0;
            wait_cnt <= '0;
            beat_cnt <= '0;
            sz       <= '0;
            lane     <= 1'b0;
            wdata_hi <= '0;
            stage    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            bus      <= bus_n;
            addr_q   <= addr_n;
            wait_cnt <= wait_n;
            beat_cnt <= beat_n;
            sz       <= sz_n;
            lane     <= lane_n;
            wdata_hi <= wdata_hi_n;
            stage    <= stage_n;
            data_q   <= data_n;
            err_q    <= err_n;
        end
    end

endmodule
